// File: rtl/decode_stage.sv
// decode_stage: registered MIPS instruction-decode stage between fetch and execute.
//
// Splits a 32-bit instruction into register/immediate/target fields, classifies it
// (R / I / J / illegal) and presents the registered result one clock after it is
// accepted. Valid/ready handshake on both sides, back-pressure and flush.
//
// Optional feature: define DECODE_SKID_EN to add a second (skid) entry so that
// in_ready becomes a registered output (in_ready = skid entry empty).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 discard every held instruction (redirect)
//   in_valid/in_ready     upstream handshake; insn_in and pc_in are the payload
//   out_valid/out_ready   downstream handshake
//   pc_out, opcode, rs, rt, rd, sha, func, immed_sx, immed_zx, target
//                         decoded fields (fields unused by the class are 0)
//   insn_class            0 = R, 1 = I, 2 = J, 3 = illegal
//   illegal               insn_class == 3
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     insn_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      sha,
  output logic [5:0]      func,
  output logic [XLEN-1:0] immed_sx,
  output logic [XLEN-1:0] immed_zx,
  output logic [25:0]     target,
  output logic [1:0]      insn_class,
  output logic            illegal
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = XLEN - IMM_W;

  localparam logic [1:0] CLS_R   = 2'd0;
  localparam logic [1:0] CLS_I   = 2'd1;
  localparam logic [1:0] CLS_J   = 2'd2;
  localparam logic [1:0] CLS_ILL = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sha;
    logic [5:0]      func;
    logic [XLEN-1:0] immed_sx;
    logic [XLEN-1:0] immed_zx;
    logic [25:0]     target;
    logic [1:0]      insn_class;
    logic            illegal;
  } entry_t;

  entry_t dec;
  entry_t main_q;
  logic   main_valid;
  logic   in_xfer;

  // Combinational decode of the incoming instruction; unused fields stay 0.
  always_comb begin
    dec        = '0;
    dec.pc     = pc_in;
    dec.opcode = insn_in[31:26];
    case (insn_in[31:26]) inside
      6'h00, 6'h1C: begin
        dec.insn_class = CLS_R;
        dec.rs         = insn_in[25:21];
        dec.rt         = insn_in[20:16];
        dec.rd         = insn_in[15:11];
        dec.sha        = insn_in[10:6];
        dec.func       = insn_in[5:0];
      end
      6'h02, 6'h03: begin
        dec.insn_class = CLS_J;
        dec.target     = insn_in[25:0];
      end
      6'h01, [6'h04:6'h0F], [6'h20:6'h26], [6'h28:6'h2B], 6'h2E: begin
        dec.insn_class = CLS_I;
        dec.rs         = insn_in[25:21];
        dec.rt         = insn_in[20:16];
        dec.immed_sx   = {{EXT_W{insn_in[15]}}, insn_in[15:0]};
        dec.immed_zx   = {{EXT_W{1'b0}}, insn_in[15:0]};
      end
      default: begin
        dec.insn_class = CLS_ILL;
        dec.illegal    = 1'b1;
      end
    endcase
  end

  assign in_xfer = in_valid && in_ready;

`ifdef DECODE_SKID_EN

  entry_t skid_q;
  logic   skid_valid;
  logic   ready_q;
  logic   main_free;

  // ready_q mirrors "skid empty" so upstream sees a flop output.
  assign in_ready  = ready_q;
  assign main_free = !main_valid || out_ready;

  // Main entry refills from skid first to keep program order.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
      end else if (in_xfer) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

`else

  // Accept when empty, draining this cycle, or being flushed (input is dropped).
  assign in_ready = !main_valid || out_ready || flush;

  // Single entry: load on input transfer, clear on output transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_q     <= dec;
    end else if (out_valid && out_ready) begin
      main_valid <= 1'b0;
    end
  end

`endif

  assign out_valid  = main_valid;
  assign pc_out     = main_q.pc;
  assign opcode     = main_q.opcode;
  assign rs         = main_q.rs;
  assign rt         = main_q.rt;
  assign rd         = main_q.rd;
  assign sha        = main_q.sha;
  assign func       = main_q.func;
  assign immed_sx   = main_q.immed_sx;
  assign immed_zx   = main_q.immed_zx;
  assign target     = main_q.target;
  assign insn_class = main_q.insn_class;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + scoreboard bench for decode_stage (XLEN = 32).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well before
// the next rising edge. Accepted instructions are pushed as expected entries and
// popped on each output transfer.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, illegal;
  logic [31:0] insn_in, pc_in, pc_out, immed_sx, immed_zx;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, sha;
  logic [25:0] target;
  logic [1:0]  insn_class;

  decode_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .insn_in(insn_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sha(sha), .func(func),
    .immed_sx(immed_sx), .immed_zx(immed_zx), .target(target),
    .insn_class(insn_class), .illegal(illegal)
  );

  always #5 clock = ~clock;

`ifdef DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [34:0] fields;  // opcode, rs, rt, rd, sha, func, class, illegal
    logic [63:0] imm;     // immed_sx, immed_zx
    logic [25:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference decode written from the opcode map.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t        e;
    logic [5:0]  op;
    logic [1:0]  cls;
    logic [4:0]  f_rs, f_rt, f_rd, f_sha;
    logic [5:0]  f_fn;
    logic [31:0] sx, zx;
    logic [25:0] tg;
    op = i[31:26];
    f_rs = 0; f_rt = 0; f_rd = 0; f_sha = 0; f_fn = 0; sx = 0; zx = 0; tg = 0;
    if (op == 6'h00 || op == 6'h1C) begin
      cls = 0; f_rs = i[25:21]; f_rt = i[20:16]; f_rd = i[15:11]; f_sha = i[10:6]; f_fn = i[5:0];
    end else if (op == 6'h02 || op == 6'h03) begin
      cls = 2; tg = i[25:0];
    end else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h26) ||
                 (op >= 6'h28 && op <= 6'h2B) || op == 6'h2E) begin
      cls = 1; f_rs = i[25:21]; f_rt = i[20:16];
      sx = i[15] ? (32'hFFFF0000 | 32'(i[15:0])) : 32'(i[15:0]);
      zx = 32'(i[15:0]);
    end else begin
      cls = 3;
    end
    e.pc     = p;
    e.fields = {op, f_rs, f_rt, f_rd, f_sha, f_fn, cls, (cls == 2'd3)};
    e.imm    = {sx, zx};
    e.tgt    = tg;
    return e;
  endfunction

  // One clock: drive, check any output transfer, track acceptance, advance.
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic ordy, input logic fl, input logic rst, output logic acc);
    exp_t e;
    in_valid = v; insn_in = i; pc_in = p; out_ready = ordy; flush = fl; reset = rst;
    #1;
    acc = v && in_ready && !fl && !rst;
    if (!fl && !rst && out_valid && out_ready) begin
      chk("sb_underflow", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc", 64'(pc_out), 64'(e.pc));
        chk("sb_fields", 64'({opcode, rs, rt, rd, sha, func, insn_class, illegal}), 64'(e.fields));
        chk("sb_imm", {immed_sx, immed_zx}, e.imm);
        chk("sb_target", 64'(target), 64'(e.tgt));
      end
    end
    if (fl || rst) q.delete();
    else if (acc) q.push_back(model(i, p));
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [31:0] bp_insn [4];
  logic [31:0] bp_pc   [4];
  logic [5:0]  ops     [12];

  initial begin
    logic acc;
    int   idx;
    int   sel;
    logic [31:0] r;

    reset = 1; flush = 0; in_valid = 0; out_ready = 0; insn_in = 0; pc_in = 0;
    @(negedge clock);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    reset = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_pc_out", 64'(pc_out), 0);
    chk("rst_class", 64'(insn_class), 0);
    chk("rst_illegal", 64'(illegal), 0);
    @(negedge clock);

    // Back-to-back stream, one instruction per clock.
    step(1, 32'h012A4020, 32'h400, 1, 0, 0, acc);
    chk("add_valid", 64'(out_valid), 1);
    chk("add_class", 64'(insn_class), 0);
    chk("add_regs", 64'({rs, rt, rd, sha}), 64'({5'd9, 5'd10, 5'd8, 5'd0}));
    chk("add_func", 64'(func), 64'h20);
    chk("add_imm", 64'(immed_sx), 0);
    chk("add_pc", 64'(pc_out), 64'h400);
    step(1, 32'h2108FFFC, 32'h404, 1, 0, 0, acc);
    chk("addi_class", 64'(insn_class), 1);
    chk("addi_rs_rt", 64'({rs, rt}), 64'({5'd8, 5'd8}));
    chk("addi_sx", 64'(immed_sx), 64'hFFFFFFFC);
    chk("addi_zx", 64'(immed_zx), 64'h0000FFFC);
    chk("addi_rd_sha_func", 64'({rd, sha, func}), 0);
    step(1, 32'h0C100010, 32'h408, 1, 0, 0, acc);
    chk("jal_class", 64'(insn_class), 2);
    chk("jal_target", 64'(target), 64'h0100010);
    chk("jal_rs", 64'(rs), 0);
    step(1, 32'hFC000000, 32'h40C, 1, 0, 0, acc);
    chk("ill_class", 64'(insn_class), 3);
    chk("ill_flag", 64'(illegal), 1);
    chk("ill_valid", 64'(out_valid), 1);
    chk("ill_opcode", 64'(opcode), 64'h3F);
    step(0, 0, 0, 1, 0, 0, acc);
    chk("idle_valid", 64'(out_valid), 0);

    // Back-pressure: out_ready low for the first three cycles.
    bp_insn[0] = 32'h01095020; bp_insn[1] = 32'h8D280004;
    bp_insn[2] = 32'h08000040; bp_insn[3] = 32'h3C01ABCD;
    bp_pc[0] = 32'h500; bp_pc[1] = 32'h504; bp_pc[2] = 32'h508; bp_pc[3] = 32'h50C;
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || out_valid); c++) begin
      sel = (idx < 4) ? idx : 0;
      step(idx < 4, bp_insn[sel], bp_pc[sel], c >= 3, 0, 0, acc);
      if (acc) idx++;
      if (c == 0) chk("bp_ready_after_1st", 64'(in_ready), SKID ? 64'd1 : 64'd0);
      if (c == 1) begin
        chk("bp_ready_after_2nd", 64'(in_ready), 0);
        chk("bp_hold_pc1", 64'(pc_out), 64'h500);
      end
      if (c == 2) begin
        chk("bp_hold_pc2", 64'(pc_out), 64'h500);
        chk("bp_hold_func", 64'(func), 64'h20);
        chk("bp_hold_valid", 64'(out_valid), 1);
      end
    end
    chk("bp_all_accepted", 64'(idx), 4);
    chk("bp_all_emerged", 64'(q.size()), 0);

    // Flush with entries full and a coincident input.
    step(1, 32'h00000020, 32'h600, 0, 0, 0, acc);
    step(1, 32'h24020001, 32'h604, 0, 0, 0, acc);
    step(1, 32'h24030002, 32'h608, 0, 1, 0, acc);
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ready", 64'(in_ready), 1);
    step(0, 0, 0, 1, 0, 0, acc);
    chk("flush_valid_later", 64'(out_valid), 0);

    // Reset over flush, input and stall while full.
    step(1, 32'h00851020, 32'h700, 0, 0, 0, acc);
    step(1, 32'hAC220008, 32'h704, 0, 0, 0, acc);
    step(1, 32'h0C000123, 32'h708, 0, 1, 1, acc);
    chk("rst2_valid", 64'(out_valid), 0);
    chk("rst2_ready", 64'(in_ready), 1);
    chk("rst2_pc", 64'(pc_out), 0);
    chk("rst2_fields", 64'({opcode, rs, rt, rd, sha, func, insn_class, illegal}), 0);
    chk("rst2_imm_tgt", 64'({immed_sx, target}), 0);
    step(0, 0, 0, 1, 0, 0, acc);
    chk("rst2_valid_later", 64'(out_valid), 0);

    // Random traffic through the scoreboard.
    ops = '{6'h00, 6'h1C, 6'h02, 6'h03, 6'h01, 6'h0F, 6'h20, 6'h26, 6'h28, 6'h2B, 6'h2E, 6'h27};
    for (int c = 0; c < 60; c++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[31:26] = ops[$urandom_range(0, 11)];
      step($urandom_range(0, 3) != 0, r, 32'h1000 + 32'(c * 4), $urandom_range(0, 3) != 0, 0, 0, acc);
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) step(0, 0, 0, 1, 0, 0, acc);
    chk("drain_empty", 64'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
